// File: rtl/div_iter_param.sv
// div_iter_param: multi-cycle radix-2^BPC restoring divider for the EX stage.
// Signed or unsigned. Uses a start/ready handshake, with annul, busy and stall request.
// Optional feature macro: DIV_EARLY_OUT_EN. When it is defined, |dividend| < |divisor|
// skips the iteration phase and completes in one cycle with q=0 and r=dividend.
module div_iter_param #(
   parameter int WIDTH = 32,
   parameter int BPC   = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               signed_i,
   input  logic               annul_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               busy_o,
   output logic               stallreq_o
);
   localparam int ITER = WIDTH / BPC;
   localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   quo_q, quo_d;     // dividend shifts out, quotient shifts in
   logic [WIDTH-1:0]   rem_q, rem_d;     // partial remainder (always < divisor)
   logic [WIDTH-1:0]   dvs_q, dvs_d;     // divisor magnitude
   logic               q_neg_q, q_neg_d;
   logic               r_neg_q, r_neg_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;

   logic               op1_neg, op2_neg;
   logic [WIDTH-1:0]   abs1, abs2;
   logic [WIDTH:0]     trial;
   logic [WIDTH-1:0]   step_rem, step_quo, rem_fin, quo_fin;

   // Operand magnitudes; the most negative value maps onto itself as an unsigned magnitude.
   always_comb begin
      op1_neg = signed_i & opdata1_i[WIDTH-1];
      op2_neg = signed_i & opdata2_i[WIDTH-1];
      abs1    = op1_neg ? -opdata1_i : opdata1_i;
      abs2    = op2_neg ? -opdata2_i : opdata2_i;
   end

   // BPC cascaded compare/subtract steps per cycle on a WIDTH+1-bit trial remainder, then sign fix-up.
   always_comb begin
      step_rem = rem_q;
      step_quo = quo_q;
      trial    = '0;
      for (int i = 0; i < BPC; i++) begin
         trial    = {step_rem, step_quo[WIDTH-1]};
         step_quo = {step_quo[WIDTH-2:0], 1'b0};
         if (trial >= {1'b0, dvs_q}) begin
            trial       = trial - {1'b0, dvs_q};
            step_quo[0] = 1'b1;
         end
         step_rem = trial[WIDTH-1:0];
      end
      rem_fin = r_neg_q ? -step_rem : step_rem;
      quo_fin = q_neg_q ? -step_quo : step_quo;
   end

   // Hold EX while a request is pending and no result is being presented.
   assign stallreq_o = start_i & ~annul_i & (state_q != S_DONE);

   // Next-state and datapath updates; annul overrides everything except reset.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      dvs_d    = dvs_q;
      q_neg_d  = q_neg_q;
      r_neg_d  = r_neg_q;
      result_d = result_q;
      ready_d  = ready_q;
      busy_d   = busy_q;
      if (annul_i) begin
         state_d = S_IDLE;
         ready_d = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  if (opdata2_i == '0) begin
                     state_d  = S_DONE;
                     result_d = '0;
                     ready_d  = 1'b1;
                  end
`ifdef DIV_EARLY_OUT_EN
                  else if (abs1 < abs2) begin
                     state_d  = S_DONE;
                     result_d = {opdata1_i, {WIDTH{1'b0}}};
                     ready_d  = 1'b1;
                  end
`endif
                  else begin
                     quo_d   = abs1;
                     dvs_d   = abs2;
                     rem_d   = '0;
                     q_neg_d = op1_neg ^ op2_neg;
                     r_neg_d = op1_neg;
                     cnt_d   = '0;
                     state_d = S_RUN;
                     busy_d  = 1'b1;
                  end
               end
            end
            S_RUN: begin
               quo_d = step_quo;
               rem_d = step_rem;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(ITER - 1)) begin
                  state_d  = S_DONE;
                  busy_d   = 1'b0;
                  ready_d  = 1'b1;
                  result_d = {rem_fin, quo_fin};
               end
            end
            S_DONE: begin
               if (!start_i) begin
                  state_d = S_IDLE;
                  ready_d = 1'b0;
               end
            end
            default: begin
               state_d = S_IDLE;
               ready_d = 1'b0;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   // State and datapath registers; synchronous reset discards any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         dvs_q    <= '0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         dvs_q    <= dvs_d;
         q_neg_q  <= q_neg_d;
         r_neg_q  <= r_neg_d;
         result_q <= result_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;
   assign busy_o   = busy_q;

endmodule

// File: tb/tb_div_iter_param.sv
// Bench for div_iter_param: a BPC=1 and a BPC=4 instance share one stimulus stream.
// A transaction-level model predicts ready/busy/result/stallreq for both every cycle.
module tb_div_iter_param;
`ifdef DIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst, start, sgn, annul;
   logic [31:0]       op1, op2;
   logic [1:0]        rdy, bsy, stl;
   logic [1:0][63:0]  res;
   int                checks = 0;
   int                failures = 0;
   bit                chk_en = 1'b0;

   always #5 clk = ~clk;

   div_iter_param #(.WIDTH(32), .BPC(1)) u_b1 (
      .clk(clk), .rst(rst), .start_i(start), .signed_i(sgn), .annul_i(annul),
      .opdata1_i(op1), .opdata2_i(op2), .result_o(res[0]), .ready_o(rdy[0]),
      .busy_o(bsy[0]), .stallreq_o(stl[0]));

   div_iter_param #(.WIDTH(32), .BPC(4)) u_b4 (
      .clk(clk), .rst(rst), .start_i(start), .signed_i(sgn), .annul_i(annul),
      .opdata1_i(op1), .opdata2_i(op2), .result_o(res[1]), .ready_o(rdy[1]),
      .busy_o(bsy[1]), .stallreq_o(stl[1]));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Reference quotient/remainder from plain integer arithmetic ({r, q}).
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
      longint sa, sb, q, r;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'(a);
         sb = longint'(b);
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
      return (s && x[31]) ? -x : x;
   endfunction

   function automatic int lat_of(input int k);
      return (k == 0) ? 32 : 8;
   endfunction

   // Model: phase 0 idle, 1 computing, 2 presenting result.
   int          m_ph   [2];
   int          m_left [2];
   logic [63:0] m_res  [2];
   logic [63:0] m_pend [2];
   logic        m_rdy  [2];
   logic        m_bsy  [2];

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_ph[k] <= 0; m_res[k] <= '0; m_rdy[k] <= 1'b0; m_bsy[k] <= 1'b0;
         end else if (annul) begin
            m_ph[k] <= 0; m_rdy[k] <= 1'b0; m_bsy[k] <= 1'b0;
         end else begin
            case (m_ph[k])
               0: if (start) begin
                  if (op2 == 32'd0) begin
                     m_ph[k] <= 2; m_res[k] <= '0; m_rdy[k] <= 1'b1;
                  end else if (EARLY && (mag(op1, sgn) < mag(op2, sgn))) begin
                     m_ph[k] <= 2; m_res[k] <= {op1, 32'd0}; m_rdy[k] <= 1'b1;
                  end else begin
                     m_pend[k] <= ref_div(op1, op2, sgn);
                     m_left[k] <= lat_of(k);
                     m_ph[k]   <= 1;
                     m_bsy[k]  <= 1'b1;
                  end
               end
               1: begin
                  if (m_left[k] == 1) begin
                     m_ph[k] <= 2; m_bsy[k] <= 1'b0; m_rdy[k] <= 1'b1; m_res[k] <= m_pend[k];
                  end else begin
                     m_left[k] <= m_left[k] - 1;
                  end
               end
               2: if (!start) begin
                  m_ph[k] <= 0; m_rdy[k] <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   // Compare process: every cycle, away from the rising edge.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
               chk($sformatf("ready_b%0d", k), rdy[k], m_rdy[k]);
               chk($sformatf("busy_b%0d", k), bsy[k], m_bsy[k]);
               chk($sformatf("result_b%0d", k), res[k], m_res[k]);
               chk($sformatf("stallreq_b%0d", k), stl[k], start & ~annul & (m_ph[k] != 2));
            end
         end
      end
   end

   // One directed operation with start held until the BPC=1 instance is ready.
   task automatic run_dir(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp, input int l1, input int l4);
      int lat [2];
      lat[0] = 0;
      lat[1] = 0;
      op1 = a; op2 = b; sgn = s; start = 1'b1;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         #1;
         for (int k = 0; k < 2; k++) begin
            if (rdy[k] && lat[k] == 0) begin
               lat[k] = c;
               chk($sformatf("%s_res_b%0d", nm, k), res[k], exp);
            end
         end
         if (lat[0] != 0) break;
      end
      chk({nm, "_lat_b1"}, lat[0], l1);
      chk({nm, "_lat_b4"}, lat[1], l4);
      chk({nm, "_stall_done"}, stl, 2'b00);
      start = 1'b0;
      @(negedge clk);
      #1;
      chk({nm, "_ready_drop"}, rdy, 2'b00);
   endtask

   function automatic logic [31:0] rnd_op();
      logic [31:0] v;
      case ($urandom_range(0, 5))
         0:       v = 32'd0;
         1:       v = 32'h8000_0000;
         2:       v = 32'hFFFF_FFFF;
         3:       v = 32'($urandom_range(0, 20));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      int drop_at;
      rst = 1'b1; start = 1'b0; sgn = 1'b0; annul = 1'b0; op1 = '0; op2 = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_ready", rdy, 2'b00);
      chk("reset_busy", bsy, 2'b00);
      chk("reset_result", res[0] | res[1], 64'd0);
      rst = 1'b0;
      chk_en = 1'b1;

      // Pin the reference model with hand-computed values.
      chk("model_100_7", ref_div(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
      chk("model_m7_2", ref_div(32'hFFFF_FFF9, 32'd2, 1'b1), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      chk("model_7_m2", ref_div(32'd7, 32'hFFFF_FFFE, 1'b1), {32'd1, 32'hFFFF_FFFD});
      chk("model_min_m1", ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'd0, 32'h8000_0000});
      chk("model_1000_3", ref_div(32'd1000, 32'd3, 1'b0), {32'd1, 32'd333});
      chk("model_u_max_3", ref_div(32'hFFFF_FFFF, 32'd3, 1'b0), {32'd0, 32'h5555_5555});

      run_dir("u100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, 9);
      run_dir("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 9);
      run_dir("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD}, 33, 9);
      run_dir("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, 33, 9);
      run_dir("u1000_3", 32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, 33, 9);
      run_dir("div0", 32'd5, 32'd0, 1'b1, 64'd0, 1, 1);
      run_dir("u3_100", 32'd3, 32'd100, 1'b0, {32'd3, 32'd0}, EARLY ? 1 : 33, EARLY ? 1 : 9);

      // Annul ten cycles into the run, holding start so the request must not be re-accepted.
      op1 = 32'd123456; op2 = 32'd77; sgn = 1'b0; start = 1'b1;
      repeat (11) @(negedge clk);
      annul = 1'b1;
      @(negedge clk);
      #1;
      chk("annul_busy", bsy, 2'b00);
      chk("annul_ready", rdy, 2'b00);
      @(negedge clk);
      #1;
      chk("annul_no_accept", bsy, 2'b00);
      annul = 1'b0; start = 1'b0;
      @(negedge clk);
      run_dir("u50_5", 32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, 33, 9);

      // Reset in the middle of an operation.
      op1 = 32'd999; op2 = 32'd4; start = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("midreset_busy", bsy, 2'b00);
      chk("midreset_result", res[0], 64'd0);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);

      // Randomized traffic: early start drop, stray annuls, operand churn after acceptance.
      for (int n = 0; n < 120; n++) begin
         op1 = rnd_op(); op2 = rnd_op(); sgn = 1'($urandom_range(0, 1)); start = 1'b1;
         drop_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 30)) : 0;
         for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (rdy[0] && start) break;
            annul = ($urandom_range(0, 39) == 0);
            if (c == drop_at) start = 1'b0;
            if (c > 1 && $urandom_range(0, 3) == 0) begin
               op1 = $urandom;
               sgn = 1'($urandom_range(0, 1));
            end
         end
         start = 1'b0; annul = 1'b0;
         for (int w = 0; w < 40 && bsy != 2'b00; w++) @(negedge clk);
         chk("drain_busy", bsy, 2'b00);
         @(negedge clk);
      end

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
